dmem_arbiter: RTL
=================

# dmem_arbiter

Single-port data-cache arbiter between the reorder buffer's store-commit port and the load/store buffer's load-issue port. It grants the cache to one requester at a time, holds that requester's request stable until the cache responds, and routes the response back to its owner. Committed stores win by default. A one-shot load-priority bit stops loads from starving behind back-to-back stores. A pipeline `flush` squashes an in-flight load result without aborting the cache access.

## Interface
Parameters:
- `TAG_W`, default 4: width of the ROB tag carried with each load.

Ports:
- `clk` in 1: system clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `st_req` in 1: store request from the ROB. Held high until `st_resp`.
- `st_addr` in 32: store byte address.
- `st_wdata` in 32: store data.
- `st_byte_enable` in 4: store byte lanes.
- `st_resp` out 1: one-cycle pulse to the ROB when the store completes.
- `ld_req` in 1: load request from the load/store buffer.
- `ld_addr` in 32: load byte address.
- `ld_tag` in TAG_W: ROB tag of the load.
- `ld_ready` out 1: a load is accepted on any edge where `ld_req && ld_ready`.
- `ld_valid` out 1: one-cycle pulse carrying load data back to the load/store buffer.
- `ld_rdata` out 32: load data. Valid only while `ld_valid` is high.
- `ld_resp_tag` out TAG_W: tag of the returning load.
- `flush` in 1: pipeline flush from the ROB.
- `d_read` out 1: cache read strobe.
- `d_write` out 1: cache write strobe.
- `d_addr` out 32: cache address.
- `d_wdata` out 32: cache write data.
- `d_byte_enable` out 4: cache byte lanes.
- `d_rdata` in 32: cache read data.
- `d_resp` in 1: cache response, one cycle per access.

## Operation
- States: IDLE, STORE, LOAD.
- Registers: `addr_q`, `wdata_q`, `be_q`, `tag_q`, `squash_q`, `prio_ld_q`.
- IDLE grant decision:
  - A store is taken when `st_req && !(prio_ld_q && ld_req)`. Latch `st_addr`/`st_wdata`/`st_byte_enable`, then go to STORE.
  - Otherwise a load is taken when `ld_req && !flush`. Latch `ld_addr`/`ld_tag`, clear `squash_q`, clear `prio_ld_q`, then go to LOAD.
  - `ld_ready` is high exactly when that load grant would fire. It is combinational in IDLE and 0 in every other state.
- STORE:
  - `d_write=1`, `d_addr=addr_q`, `d_wdata=wdata_q`, `d_byte_enable=be_q`.
  - On `d_resp`: `st_resp=1` in that same cycle, then return to IDLE.
  - If `ld_req` is high in that cycle, set `prio_ld_q`.
  - `flush` has no effect; a committed store always completes.
- LOAD:
  - `d_read=1`, `d_addr=addr_q`, `d_byte_enable=4'b1111`.
  - On `d_resp`: `ld_valid = !squash_q && !flush`, `ld_rdata=d_rdata`, `ld_resp_tag=tag_q`, then return to IDLE.
  - `flush` in LOAD without `d_resp` sets `squash_q`. The access runs to completion and its result is dropped.
- In IDLE with `ld_req` low, `prio_ld_q` clears.
- Outputs are Moore-decoded from state and latched registers, except `st_resp`, `ld_valid`, `ld_rdata` and `ld_ready`.
- In IDLE: `d_read`, `d_write`, `d_addr`, `d_wdata` and `d_byte_enable` are all 0.

## Timing
- Reset (`rst`=0, asynchronous):
  - state=IDLE.
  - All latches, `squash_q` and `prio_ld_q` = 0.
  - Every output = 0, including `ld_ready` while `rst` is low.
  - Reset mid-access abandons it; no response is forwarded.
- Grant edge k: `d_read` or `d_write` is first high in cycle k+1.
- Best case, `d_resp` in cycle k+1: `st_resp`/`ld_valid` pulse in cycle k+1, and the arbiter is back in IDLE at cycle k+2.
- One idle cycle always separates consecutive accesses, so throughput is at most one access per 2 cycles.
- Strobes and the address stay stable from grant until `d_resp` inclusive.
- `st_req` and `ld_req` held across a busy period are serviced once the arbiter returns to IDLE. Requests are never lost while held.
- `flush` arriving in the same cycle as `d_resp` in LOAD suppresses `ld_valid`.

## Test plan
- Store only: `st_req`, addr 0x100, data 0xDEADBEEF, be 0xF, cache responds after 3 cycles.
  - `d_write`=1 for exactly 3 cycles with stable addr/data.
  - `st_resp` pulses once.
  - Arbiter is back in IDLE.
- Load only: `ld_tag`=5, addr 0x40, `d_rdata`=0x12345678.
  - `ld_ready`=1 at the request edge.
  - `ld_valid` pulses with data 0x12345678 and tag 5.
  - `d_byte_enable`=0xF.
- Simultaneous: `st_req` and `ld_req` both rise in IDLE and stay high.
  - Store is granted first.
  - After `st_resp`, the load is granted even though `st_req` immediately re-asserts; `prio_ld_q` is exercised.
- Flush: assert `flush` 1 cycle after the load grant, `d_resp` 2 cycles later.
  - `d_read` stays high until `d_resp`.
  - `ld_valid` stays 0.
  - The next load returns normally.
- Flush during store: `flush` pulses mid-STORE.
  - `d_write` is unchanged.
  - `st_resp` still pulses.
- Reset: drop `rst` mid-LOAD.
  - All outputs go to 0 immediately.
  - After release the arbiter is in IDLE, and a new store completes correctly.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Single-port data-cache arbiter between the ROB store-commit port and the
//   load/store buffer load-issue port. One access at a time; the granted
//   request is latched and held on the cache port until d_resp, then the
//   response is routed back to its owner.
//
//   Ports
//     clk, rst                      clock, async active-low reset
//     st_req/st_addr/st_wdata/
//       st_byte_enable, st_resp     store commit request / completion pulse
//     ld_req/ld_addr/ld_tag,
//       ld_ready                    load issue handshake
//     ld_valid/ld_rdata/ld_resp_tag load return
//     flush                         squashes an in-flight load result
//     d_read/d_write/d_addr/
//       d_wdata/d_byte_enable       cache request (held until d_resp)
//     d_rdata/d_resp                cache response
module dmem_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_req,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_wdata,
  input  logic [3:0]       st_byte_enable,
  output logic             st_resp,
  input  logic             ld_req,
  input  logic [31:0]      ld_addr,
  input  logic [TAG_W-1:0] ld_tag,
  output logic             ld_ready,
  output logic             ld_valid,
  output logic [31:0]      ld_rdata,
  output logic [TAG_W-1:0] ld_resp_tag,
  input  logic             flush,
  output logic             d_read,
  output logic             d_write,
  output logic [31:0]      d_addr,
  output logic [31:0]      d_wdata,
  output logic [3:0]       d_byte_enable,
  input  logic [31:0]      d_rdata,
  input  logic             d_resp
);

  typedef enum logic [1:0] {IDLE, STORE, LOAD} state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       be_q;
  logic [TAG_W-1:0] tag_q;
  logic             squash_q, prio_ld_q;
  logic             st_grant, ld_grant;

  // Stores win unless a load has been owed a turn since the last store
  // completed while it was waiting.
  always_comb begin
    st_grant      = 1'b0;
    ld_grant      = 1'b0;
    state_d       = state_q;
    ld_ready      = 1'b0;
    st_resp       = 1'b0;
    ld_valid      = 1'b0;
    ld_rdata      = '0;
    ld_resp_tag   = '0;
    d_read        = 1'b0;
    d_write       = 1'b0;
    d_addr        = '0;
    d_wdata       = '0;
    d_byte_enable = '0;
    unique case (state_q)
      IDLE: begin
        st_grant = st_req && !(prio_ld_q && ld_req);
        ld_grant = !st_grant && ld_req && !flush;
        // reset gating keeps ld_ready low while rst is asserted
        ld_ready = ld_grant && rst;
        if (st_grant)      state_d = STORE;
        else if (ld_grant) state_d = LOAD;
      end
      STORE: begin
        d_write       = 1'b1;
        d_addr        = addr_q;
        d_wdata       = wdata_q;
        d_byte_enable = be_q;
        st_resp       = d_resp;
        if (d_resp) state_d = IDLE;
      end
      LOAD: begin
        d_read        = 1'b1;
        d_addr        = addr_q;
        d_byte_enable = 4'b1111;
        ld_resp_tag   = tag_q;
        // a same-cycle flush also kills the returning result
        ld_valid      = d_resp && !squash_q && !flush;
        ld_rdata      = ld_valid ? d_rdata : '0;
        if (d_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      tag_q     <= '0;
      squash_q  <= 1'b0;
      prio_ld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (!ld_req) prio_ld_q <= 1'b0;
          if (st_grant) begin
            addr_q  <= st_addr;
            wdata_q <= st_wdata;
            be_q    <= st_byte_enable;
          end else if (ld_grant) begin
            addr_q    <= ld_addr;
            tag_q     <= ld_tag;
            squash_q  <= 1'b0;
            prio_ld_q <= 1'b0;
          end
        end
        STORE: begin
          // a load that waited through this store goes next
          if (d_resp && ld_req) prio_ld_q <= 1'b1;
        end
        LOAD: begin
          // the cache access is not aborted; only its result is dropped
          if (flush && !d_resp) squash_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
